// File: rtl/inst_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU-op encodings and the decode output record.
package cpu_defs;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm32;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        ctrl_t           ctrl;
        logic            out_valid;
    } dec_t;

endpackage

// File: rtl/inst_decode_if.sv
// Fetch/hazard/write-back inputs and registered decode outputs of the decode stage.
interface inst_decode_if;
    import cpu_defs::*;

    logic [31:0]     inst;
    logic            inst_valid;
    logic            stall;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm32;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic            illegal;
    logic            out_valid;

    modport master (
        input  inst, inst_valid, stall, flush, wb_we, wb_addr, wb_data,
        output rs1_data, rs2_data, imm32, rd, rs1, rs2, funct3, funct7b5,
               branch, jump, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
               alu_op, illegal, out_valid
    );

    modport slave (
        output inst, inst_valid, stall, flush, wb_we, wb_addr, wb_data,
        input  rs1_data, rs2_data, imm32, rd, rs1, rs2, funct3, funct7b5,
               branch, jump, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
               alu_op, illegal, out_valid
    );

endinterface

// File: rtl/inst_decode_reg_file.sv
// Register file: NREG x XLEN, two async read ports with write-first bypass, one sync write port.
// Latency: reads combinational, write visible to array after the edge.
// Backpressure: none; writes during reset are dropped.
module reg_file #(
    parameter int XLEN           = 32,
    parameter int NREG           = 32,
    parameter int RF_RESET_CLEAR = 1,
    localparam int AW            = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            if (RF_RESET_CLEAR != 0) begin
                for (int i = 0; i < NREG; i++) regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is forced here so it never depends on array contents.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && waddr == raddr1) rdata1 = wdata;
        if (we && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: register read, immediate generation and control decode into an output register.
// Latency: 1 cycle from inst sample to registered outputs.
// Backpressure: stall holds the output register (with write-back refresh of held operands); flush inserts a bubble.
module inst_decode #(
    parameter int XLEN           = 32,
    parameter int NREG           = 32,
    parameter int RF_RESET_CLEAR = 1
) (
    input  logic         clk,
    input  logic         rst,
    inst_decode_if.master dif
);
    import cpu_defs::*;

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    dec_t            nxt;
    dec_t            q;

    assign ins    = dif.inst;
    assign opcode = ins[6:0];

    reg_file #(
        .XLEN           (XLEN),
        .NREG           (NREG),
        .RF_RESET_CLEAR (RF_RESET_CLEAR)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (dif.wb_we),
        .waddr  (dif.wb_addr),
        .wdata  (dif.wb_data),
        .raddr1 (ins[19:15]),
        .rdata1 (rf_rd1),
        .raddr2 (ins[24:20]),
        .rdata2 (rf_rd2)
    );

    // B and J immediates are byte offsets, so bit 0 is always zero.
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        ctrl = '0;
        imm  = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
            end
            OP_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
                imm            = imm_i;
            end
            OP_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                imm             = imm_i;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm            = imm_s;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BR;
                imm         = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                imm            = imm_u;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                imm            = imm_j;
            end
            OP_JALR: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm            = imm_i;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    always_comb begin
        nxt           = '0;
        nxt.rs1_data  = rf_rd1;
        nxt.rs2_data  = rf_rd2;
        nxt.imm32     = imm;
        nxt.rd        = ins[11:7];
        nxt.rs1       = ins[19:15];
        nxt.rs2       = ins[24:20];
        nxt.funct3    = ins[14:12];
        nxt.funct7b5  = ins[30];
        nxt.ctrl      = ctrl;
        nxt.out_valid = 1'b1;
    end

    // While stalled, refresh held operands from write-back so release never issues stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (dif.flush || (!dif.stall && !dif.inst_valid)) begin
            q <= '0;
        end else if (dif.stall) begin
            if (dif.wb_we && dif.wb_addr == q.rs1 && q.rs1 != 5'd0) q.rs1_data <= dif.wb_data;
            if (dif.wb_we && dif.wb_addr == q.rs2 && q.rs2 != 5'd0) q.rs2_data <= dif.wb_data;
        end else begin
            q <= nxt;
        end
    end

    assign dif.rs1_data   = q.rs1_data;
    assign dif.rs2_data   = q.rs2_data;
    assign dif.imm32      = q.imm32;
    assign dif.rd         = q.rd;
    assign dif.rs1        = q.rs1;
    assign dif.rs2        = q.rs2;
    assign dif.funct3     = q.funct3;
    assign dif.funct7b5   = q.funct7b5;
    assign dif.branch     = q.ctrl.branch;
    assign dif.jump       = q.ctrl.jump;
    assign dif.mem_read   = q.ctrl.mem_read;
    assign dif.mem_write  = q.ctrl.mem_write;
    assign dif.mem_to_reg = q.ctrl.mem_to_reg;
    assign dif.alu_src    = q.ctrl.alu_src;
    assign dif.reg_write  = q.ctrl.reg_write;
    assign dif.alu_op     = q.ctrl.alu_op;
    assign dif.illegal    = q.ctrl.illegal;
    assign dif.out_valid  = q.out_valid;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: scoreboard of expected output records, one task per scenario.
module tb_inst_decode;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm32;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  ctl;
        logic [1:0]  alu_op;
        logic        illegal;
        logic        out_valid;
    } obs_t;

    // ctl bit order: branch, jump, mem_read, mem_write, mem_to_reg, alu_src, reg_write
    localparam logic [6:0] C_BR  = 7'b1000000;
    localparam logic [6:0] C_J   = 7'b0100000;
    localparam logic [6:0] C_MR  = 7'b0010000;
    localparam logic [6:0] C_MW  = 7'b0001000;
    localparam logic [6:0] C_M2R = 7'b0000100;
    localparam logic [6:0] C_AS  = 7'b0000010;
    localparam logic [6:0] C_RW  = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_decode_if dif();

    inst_decode #(.XLEN(32), .NREG(32), .RF_RESET_CLEAR(1)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    obs_t        sb[$];
    logic [31:0] rf[32];

    task automatic drive(input logic [31:0] i, input logic v, input logic st, input logic fl,
                         input logic we, input logic [4:0] a, input logic [31:0] d);
        dif.inst = i; dif.inst_valid = v; dif.stall = st; dif.flush = fl;
        dif.wb_we = we; dif.wb_addr = a; dif.wb_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        end else if (dif.wb_we && dif.wb_addr != 5'd0) begin
            rf[dif.wb_addr] = dif.wb_data;
        end
        #1;
    endtask

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (dif.wb_we && dif.wb_addr == a) return dif.wb_data;
        return rf[a];
    endfunction

    function automatic obs_t mk(input logic [31:0] i, input logic [6:0] ctl, input logic [1:0] op,
                                input logic [31:0] imm, input logic ill);
        obs_t e;
        e = '0;
        e.rs1_data = rdm(i[19:15]);
        e.rs2_data = rdm(i[24:20]);
        e.imm32 = imm;
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.funct3 = i[14:12]; e.funct7b5 = i[30];
        e.ctl = ctl; e.alu_op = op; e.illegal = ill; e.out_valid = 1'b1;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rs1_data = dif.rs1_data; o.rs2_data = dif.rs2_data; o.imm32 = dif.imm32;
        o.rd = dif.rd; o.rs1 = dif.rs1; o.rs2 = dif.rs2;
        o.funct3 = dif.funct3; o.funct7b5 = dif.funct7b5;
        o.ctl = {dif.branch, dif.jump, dif.mem_read, dif.mem_write, dif.mem_to_reg, dif.alu_src, dif.reg_write};
        o.alu_op = dif.alu_op; o.illegal = dif.illegal; o.out_valid = dif.out_valid;
        return o;
    endfunction

    task automatic test_reset();
        obs_t e, o;
        logic [4:0] a;
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step(); step();
        rst = 1'b0;
        for (int k = 1; k < 32; k++) begin
            a = k[4:0];
            drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, a, 32'hA500_0000 | k);
            sb.push_back('0);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rf_fill[%0d]: got %h want %h", k, o, e); end
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(32'h0020_80B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);
            sb.push_back('0);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_out[%0d]: got %h want %h", k, o, e); end
        end
        rst = 1'b0;
        for (int k = 1; k < 32; k++) begin
            a = k[4:0];
            drive({7'd0, a, a, 3'd0, 5'd0, 7'b0110011}, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            e = mk(dif.inst, C_RW, 2'b10, 32'h0, 1'b0);
            e.rs1_data = 32'h0; e.rs2_data = 32'h0;
            sb.push_back(e);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rf_cleared[x%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_rtype();
        obs_t e, o;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
                e = '0;
            end else begin
                drive(32'h0052_8233, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                e = mk(dif.inst, C_RW, 2'b10, 32'h0, 1'b0);
                e.rs1_data = 32'hDEAD_BEEF; e.rs2_data = 32'hDEAD_BEEF; e.rd = 5'd4;
            end
            sb.push_back(e);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rtype[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_imm_ctrl();
        obs_t e, o;
        logic [31:0] ins  [8];
        logic [6:0]  ctl  [8];
        logic [1:0]  op   [8];
        logic [31:0] imm  [8];
        ins[0] = 32'hFE00_0EE3;  ctl[0] = C_BR;                     op[0] = 2'b01; imm[0] = 32'hFFFF_FFFC;
        ins[1] = 32'h1234_50B7;  ctl[1] = C_AS | C_RW;              op[1] = 2'b00; imm[1] = 32'h1234_5000;
        ins[2] = 32'hFFF0_0093;  ctl[2] = C_AS | C_RW;              op[2] = 2'b10; imm[2] = 32'hFFFF_FFFF;
        ins[3] = {12'd8, 5'd5, 3'd2, 5'd3, 7'b0000011};
                                 ctl[3] = C_MR | C_M2R | C_AS | C_RW; op[3] = 2'b00; imm[3] = 32'h8;
        ins[4] = {7'h7F, 5'd6, 5'd5, 3'd2, 5'h1C, 7'b0100011};
                                 ctl[4] = C_MW | C_AS;              op[4] = 2'b00; imm[4] = 32'hFFFF_FFFC;
        ins[5] = {1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111};
                                 ctl[5] = C_J | C_RW;               op[5] = 2'b00; imm[5] = 32'h800;
        ins[6] = {12'd0, 5'd1, 3'd0, 5'd0, 7'b1100111};
                                 ctl[6] = C_J | C_RW | C_AS;        op[6] = 2'b00; imm[6] = 32'h0;
        ins[7] = {20'hFFFFF, 5'd2, 7'b0010111};
                                 ctl[7] = C_AS | C_RW;              op[7] = 2'b00; imm[7] = 32'hFFFF_F000;
        for (int k = 0; k < 8; k++) begin
            drive(ins[k], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            sb.push_back(mk(ins[k], ctl[k], op[k], imm[k], 1'b0));
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL imm_ctrl[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_bypass();
        obs_t e, o;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(32'h0012_8313, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7);
                1: drive(32'h0012_8313, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                2: drive(32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h9);
                default: drive(32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            endcase
            e = mk(dif.inst, C_AS | C_RW, 2'b10, (k < 2) ? 32'h1 : 32'hFFFF_FFFF, 1'b0);
            e.rs1_data = (k < 2) ? 32'h7 : 32'h0;
            sb.push_back(e);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL bypass_x0[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_stall_flush();
        obs_t e, o, held;
        logic [31:0] add456, add978, lui;
        add456 = {7'd0, 5'd6, 5'd5, 3'd0, 5'd4, 7'b0110011};
        add978 = {7'd0, 5'd8, 5'd7, 3'd0, 5'd9, 7'b0110011};
        lui    = 32'h1234_50B7;
        held   = '0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin drive(add456, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                         e = mk(add456, C_RW, 2'b10, 32'h0, 1'b0); held = e; end
                1: begin drive(lui, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h55);
                         held.rs2_data = 32'h55; e = held; end
                2: begin drive(lui, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77); e = held; end
                3: begin drive(lui, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); e = held; end
                4: begin drive(lui, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h88); e = '0; end
                5: begin drive(add978, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                         e = mk(add978, C_RW, 2'b10, 32'h0, 1'b0);
                         e.rs1_data = 32'h77; e.rs2_data = 32'h88; end
                6: begin drive(add456, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                         e = mk(add456, C_RW, 2'b10, 32'h0, 1'b0);
                         e.rs1_data = 32'h7; e.rs2_data = 32'h55; held = e; end
                default: begin drive(lui, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
                         held.rs1_data = 32'h1234; e = held; end
            endcase
            sb.push_back(e);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL stall_flush[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_illegal();
        obs_t e, o;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                drive(32'h0000_007F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                e = mk(32'h0000_007F, 7'b0, 2'b00, 32'h0, 1'b1);
            end else begin
                drive(32'h0052_8233, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
                e = '0;
            end
            sb.push_back(e);
            step();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL illegal[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_rtype();
        test_imm_ctrl();
        test_bypass();
        test_stall_flush();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
